// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the fetch/data memory-port arbiter.
// Source ids, lock states, FIFO entry layout and default depths.
package mycpu_arb_pkg;

  localparam int DEF_OUTSTANDING = 2;
  localparam int DEF_CNT_W = $clog2(DEF_OUTSTANDING) + 1;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_I = 2'd1,
    LOCK_D = 2'd2
  } lock_e;

  typedef struct packed {
    logic discard;
    logic src;
  } src_ent_t;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response bundle (req/addr_ok, data_ok/rdata).
// master drives the request side, slave answers it.
interface mem_req_arbiter_if;

  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/mem_req_arbiter_src_fifo.sv
// In-order source FIFO: {discard, src} per outstanding transaction.
// Ports: push/push_ent, pop, cancel (mark I entries), head, full, empty, count.
module arb_src_fifo
  import mycpu_arb_pkg::*;
#(
  parameter int DEPTH = DEF_OUTSTANDING,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  src_ent_t         push_ent,
  input  logic             pop,
  input  logic             cancel,
  output src_ent_t         head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  src_ent_t         mem_q [DEPTH];
  logic [PW-1:0]    wp_q;
  logic [PW-1:0]    rp_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      // Stale slots may also get marked; they are rewritten on push.
      for (int i = 0; i < DEPTH; i++) begin
        if (cancel && mem_q[i].src == SRC_I) begin
          mem_q[i].discard <= 1'b1;
        end
      end
      if (push) begin
        mem_q[wp_q] <= push_ent;
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) begin
        rp_q <= rp_q + 1'b1;
      end
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head  = mem_q[rp_q];
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one memory port between fetch (i_bus) and data (d_bus).
// Ports: clk, resetn, cancel, busy; i_bus/d_bus slave, s_bus master.
// ARB_RR_EN: round-robin instead of fixed data-over-fetch priority.
module mem_req_arbiter
  import mycpu_arb_pkg::*;
#(
  parameter int OUTSTANDING = DEF_OUTSTANDING
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cancel,
  output logic                      busy,
  mem_req_arbiter_if.slave          i_bus,
  mem_req_arbiter_if.slave          d_bus,
  mem_req_arbiter_if.master         s_bus
);

  localparam int CNT_W = $clog2(OUTSTANDING) + 1;

  lock_e            state_q;
  lock_e            state_d;
  logic             gnt_v;
  logic             gnt_src;
  logic             gnt_d;
  logic             accept;
  logic             pop;
  logic             full;
  logic             empty;
  logic             cxl;
  logic [CNT_W-1:0] count;
  src_ent_t         head;
  src_ent_t         push_ent;

`ifdef ARB_RR_EN
  logic rr_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_q <= SRC_D;
    end else if (accept) begin
      // Priority passes to the side that was not just served.
      rr_q <= ~gnt_src;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Full is taken from the registered count, so a same-cycle pop
  // does not free a slot for this cycle's grant.
  always_comb begin
    state_d = state_q;
    gnt_v   = 1'b0;
    gnt_src = SRC_D;
    if (resetn) begin
      unique case (state_q)
        LOCK_I: begin
          gnt_v   = 1'b1;
          gnt_src = SRC_I;
        end
        LOCK_D: begin
          gnt_v   = 1'b1;
          gnt_src = SRC_D;
        end
        default: begin
          if (!full) begin
`ifdef ARB_RR_EN
            if (d_bus.req && i_bus.req) begin
              gnt_v   = 1'b1;
              gnt_src = rr_q;
            end else if (d_bus.req) begin
              gnt_v   = 1'b1;
              gnt_src = SRC_D;
            end else if (i_bus.req) begin
              gnt_v   = 1'b1;
              gnt_src = SRC_I;
            end
`else
            if (d_bus.req) begin
              gnt_v   = 1'b1;
              gnt_src = SRC_D;
            end else if (i_bus.req) begin
              gnt_v   = 1'b1;
              gnt_src = SRC_I;
            end
`endif
          end
        end
      endcase
      if (state_q == IDLE) begin
        if (gnt_v && !s_bus.addr_ok) begin
          state_d = (gnt_src == SRC_I) ? LOCK_I : LOCK_D;
        end
      end else if (s_bus.addr_ok) begin
        state_d = IDLE;
      end
    end
  end

  assign gnt_d  = gnt_v && (gnt_src == SRC_D);
  assign accept = gnt_v && s_bus.addr_ok;
  assign cxl    = resetn && cancel;
  assign pop    = resetn && s_bus.data_ok && !empty;

  assign push_ent.src     = gnt_src;
  assign push_ent.discard = (gnt_src == SRC_I) && cxl;

  assign s_bus.req   = gnt_v;
  assign s_bus.wr    = gnt_d && d_bus.wr;
  assign s_bus.size  = !gnt_v ? 2'd0 :
                       gnt_d  ? d_bus.size : 2'd2;
  assign s_bus.addr  = !gnt_v ? 32'd0 :
                       gnt_d  ? d_bus.addr : i_bus.addr;
  assign s_bus.wstrb = gnt_d ? d_bus.wstrb : 4'd0;
  assign s_bus.wdata = gnt_d ? d_bus.wdata : 32'd0;

  assign i_bus.addr_ok = accept && (gnt_src == SRC_I);
  assign d_bus.addr_ok = accept && (gnt_src == SRC_D);

  // A cancel in the response cycle also suppresses that fetch.
  assign i_bus.data_ok = pop && (head.src == SRC_I)
                         && !head.discard && !cxl;
  assign d_bus.data_ok = pop && (head.src == SRC_D)
                         && !head.discard;

  assign i_bus.rdata = resetn ? s_bus.rdata : 32'd0;
  assign d_bus.rdata = resetn ? s_bus.rdata : 32'd0;

  assign busy = resetn && ((count != '0) || (state_q != IDLE));

  arb_src_fifo #(
    .DEPTH (OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_ent (push_ent),
    .pop      (pop),
    .cancel   (cxl),
    .head     (head),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter.
// Inputs change at negedge, outputs are checked 1ns later.
module tb_mem_req_arbiter;

  logic clk = 1'b0;
  logic resetn;
  logic cancel;
  logic busy;
  int   n_chk = 0;
  int   n_fail = 0;

  mem_req_arbiter_if ib ();
  mem_req_arbiter_if db ();
  mem_req_arbiter_if sb ();

  mem_req_arbiter dut (
    .clk    (clk),
    .resetn (resetn),
    .cancel (cancel),
    .busy   (busy),
    .i_bus  (ib.slave),
    .d_bus  (db.slave),
    .s_bus  (sb.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic clr();
    cancel     = 1'b0;
    ib.req     = 1'b0;
    ib.wr      = 1'b0;
    ib.size    = 2'd0;
    ib.addr    = 32'd0;
    ib.wstrb   = 4'd0;
    ib.wdata   = 32'd0;
    db.req     = 1'b0;
    db.wr      = 1'b0;
    db.size    = 2'd0;
    db.addr    = 32'd0;
    db.wstrb   = 4'd0;
    db.wdata   = 32'd0;
    sb.addr_ok = 1'b0;
    sb.data_ok = 1'b0;
    sb.rdata   = 32'd0;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    resetn = 1'b0;
    clr();
    db.req = 1'b1;
    db.addr = 32'h55;
    #2;
    chk("rst_sreq", sb.req, 0);
    chk("rst_saddr", sb.addr, 0);
    chk("rst_busy", busy, 0);
    cyc();
    clr();
    resetn = 1'b1;

    // both request, data first then fetch
    cyc();
    ib.req = 1; ib.addr = 32'h100;
    db.req = 1; db.size = 2; db.addr = 32'h200;
    sb.addr_ok = 1;
    #1;
    chk("t1_daok", db.addr_ok, 1);
    chk("t1_iaok0", ib.addr_ok, 0);
    chk("t1_saddr_d", sb.addr, 32'h200);
    cyc();
    db.req = 0;
    #1;
    chk("t1_iaok", ib.addr_ok, 1);
    chk("t1_saddr_i", sb.addr, 32'h100);
    chk("t1_ssize_i", sb.size, 2);
    chk("t1_swr_i", sb.wr, 0);
    cyc();
    ib.req = 0; sb.addr_ok = 0;
    sb.data_ok = 1; sb.rdata = 32'hAAAA;
    #1;
    chk("t1_ddok", db.data_ok, 1);
    chk("t1_idok0", ib.data_ok, 0);
    chk("t1_rdata", db.rdata, 32'hAAAA);
    cyc();
    sb.rdata = 32'hBBBB;
    #1;
    chk("t1_idok", ib.data_ok, 1);
    chk("t1_ddok0", db.data_ok, 0);
    chk("t1_irdata", ib.rdata, 32'hBBBB);
    cyc();
    clr();
    #1;
    chk("t1_idle", busy, 0);

    // fetch locked for 3 cycles, data waits
    cyc();
    ib.req = 1; ib.addr = 32'h300;
    #1;
    chk("t2_sreq", sb.req, 1);
    chk("t2_saddr0", sb.addr, 32'h300);
    for (int k = 1; k < 3; k++) begin
      cyc();
      db.req = 1; db.wr = 1; db.size = 2;
      db.addr = 32'h400; db.wstrb = 4'hF;
      db.wdata = 32'hDEAD;
      #1;
      chk("t2_saddr_lock", sb.addr, 32'h300);
      chk("t2_swr_lock", sb.wr, 0);
      chk("t2_daok_lock", db.addr_ok, 0);
      chk("t2_busy", busy, 1);
    end
    cyc();
    sb.addr_ok = 1;
    #1;
    chk("t2_iaok", ib.addr_ok, 1);
    chk("t2_daok0", db.addr_ok, 0);
    chk("t2_saddr3", sb.addr, 32'h300);
    cyc();
    ib.req = 0;
    #1;
    chk("t2_daok", db.addr_ok, 1);
    chk("t2_saddr_d", sb.addr, 32'h400);
    chk("t2_swr", sb.wr, 1);
    chk("t2_swstrb", sb.wstrb, 4'hF);
    chk("t2_swdata", sb.wdata, 32'hDEAD);
    cyc();
    db.req = 0; sb.addr_ok = 0; sb.data_ok = 1;
    #1;
    chk("t2_idok", ib.data_ok, 1);
    cyc();
    #1;
    chk("t2_ddok", db.data_ok, 1);
    cyc();
    clr();

    // full: two fetches block a third
    cyc();
    ib.req = 1; ib.addr = 32'h10; sb.addr_ok = 1;
    #1;
    chk("t3_iaok_a", ib.addr_ok, 1);
    cyc();
    ib.addr = 32'h14;
    #1;
    chk("t3_iaok_b", ib.addr_ok, 1);
    cyc();
    ib.addr = 32'h18;
    #1;
    chk("t3_full_sreq", sb.req, 0);
    chk("t3_full_busy", busy, 1);
    chk("t3_full_aok", ib.addr_ok, 0);
    cyc();
    sb.data_ok = 1;
    #1;
    chk("t3_idok", ib.data_ok, 1);
    chk("t3_pop_sreq", sb.req, 0);
    cyc();
    sb.data_ok = 0;
    #1;
    chk("t3_cnt", dut.count, 1);
    chk("t3_regrant", ib.addr_ok, 1);
    chk("t3_regrant_a", sb.addr, 32'h18);
    cyc();
    ib.req = 0; sb.addr_ok = 0; sb.data_ok = 1;
    #1;
    chk("t3_drain_a", ib.data_ok, 1);
    cyc();
    #1;
    chk("t3_drain_b", ib.data_ok, 1);
    cyc();
    clr();
    #1;
    chk("t3_idle", busy, 0);

    // cancel drops two in-flight fetches
    cyc();
    ib.req = 1; ib.addr = 32'h20; sb.addr_ok = 1;
    cyc();
    ib.addr = 32'h24;
    cyc();
    ib.req = 0; sb.addr_ok = 0; cancel = 1;
    #1;
    chk("t4_cnt2", dut.count, 2);
    cyc();
    cancel = 0; sb.data_ok = 1; sb.rdata = 32'h1111;
    #1;
    chk("t4_idok_a", ib.data_ok, 0);
    chk("t4_rdata_a", ib.rdata, 32'h1111);
    cyc();
    sb.rdata = 32'h2222;
    #1;
    chk("t4_idok_b", ib.data_ok, 0);
    chk("t4_ddok_b", db.data_ok, 0);
    cyc();
    sb.data_ok = 0; db.req = 1; db.addr = 32'h30;
    sb.addr_ok = 1;
    #1;
    chk("t4_daok", db.addr_ok, 1);
    cyc();
    db.req = 0; sb.addr_ok = 0; sb.data_ok = 1;
    #1;
    chk("t4_ddok", db.data_ok, 1);
    cyc();
    clr();

    // cancel together with LOCK_I completion
    cyc();
    ib.req = 1; ib.addr = 32'h40;
    cyc();
    cancel = 1; sb.addr_ok = 1;
    #1;
    chk("t5_iaok", ib.addr_ok, 1);
    cyc();
    ib.req = 0; cancel = 0; sb.addr_ok = 0;
    sb.data_ok = 1;
    #1;
    chk("t5_idok", ib.data_ok, 0);
    cyc();
    clr();
    #1;
    chk("t5_idle", busy, 0);

    // reset mid-transfer
    cyc();
    db.req = 1; db.addr = 32'h50; sb.addr_ok = 1;
    cyc();
    db.req = 0; sb.addr_ok = 0;
    #1;
    chk("t6_busy", busy, 1);
    #1;
    resetn = 0;
    db.req = 1; ib.req = 1; sb.addr_ok = 1;
    sb.data_ok = 1; sb.rdata = 32'h77;
    #1;
    chk("t6_sreq", sb.req, 0);
    chk("t6_busy0", busy, 0);
    chk("t6_daok", db.addr_ok, 0);
    chk("t6_ddok", db.data_ok, 0);
    chk("t6_idok", ib.data_ok, 0);
    chk("t6_rdata", db.rdata, 0);
    cyc();
    clr();
    resetn = 1;
    cyc();
    sb.data_ok = 1;
    #1;
    chk("t6_stray_d", db.data_ok, 0);
    chk("t6_stray_i", ib.data_ok, 0);
    cyc();
    sb.data_ok = 0;
    #1;
    chk("t6_idle", busy, 0);

    // continuous requests from both sides
    cyc();
    ib.req = 1; ib.addr = 32'h60;
    db.req = 1; db.addr = 32'h70;
    sb.addr_ok = 1; sb.data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef ARB_RR_EN
      chk("t7_daok", db.addr_ok, (k % 2 == 0));
      chk("t7_iaok", ib.addr_ok, (k % 2 == 1));
      if (k > 0) begin
        chk("t7_ddok", db.data_ok, (k % 2 == 1));
        chk("t7_idok", ib.data_ok, (k % 2 == 0));
      end
`else
      chk("t7_daok", db.addr_ok, 1);
      chk("t7_iaok", ib.addr_ok, 0);
      if (k > 0) begin
        chk("t7_ddok", db.data_ok, 1);
      end
`endif
      cyc();
    end
    ib.req = 0; db.req = 0; sb.addr_ok = 0;
    #1;
`ifdef ARB_RR_EN
    chk("t7_last", ib.data_ok, 1);
`else
    chk("t7_last", db.data_ok, 1);
`endif
    cyc();
    clr();
    #1;
    chk("t7_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares one SRAM-like memory port between the instruction-fetch requester (i_*) and the data requester (d_*).
- The data requester is driven by the EX/MEM stages.
- Tracks in-order outstanding transactions in a small source FIFO and routes each data_ok/rdata back to the requester that issued it.
- On pipeline exception, cancel drops responses for fetches that are still in flight.

Parameters:
- OUTSTANDING, 2, maximum accepted-but-unanswered transactions; power of 2, 2..8.
- CNT_W, 2, width of the occupancy counter; equals clog2(OUTSTANDING)+1 and is fixed by the package.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held stable until i_addr_ok.
- i_addr  in  32  fetch address; reads only, size fixed at 2'd2.
- i_addr_ok  out  1  fetch request accepted this cycle.
- i_data_ok  out  1  fetch read data valid this cycle.
- d_req  in  1  data request; held stable until d_addr_ok.
- d_wr  in  1  data request is a write.
- d_size  in  2  0 = byte, 1 = half, 2 = word.
- d_addr  in  32  data address.
- d_wstrb  in  4  byte write enables.
- d_wdata  in  32  write data.
- d_addr_ok  out  1  data request accepted.
- d_data_ok  out  1  data read returned / write acknowledged.
- rdata  out  32  s_rdata passed through to both requesters.
- cancel  in  1  pulse from the WB exception/eret path; discards pending fetch responses.
- s_req, s_wr, s_size[2], s_addr[32], s_wstrb[4], s_wdata[32]  out  request toward memory.
- s_addr_ok, s_data_ok  in  1 each  slave handshakes.
- s_rdata  in  32  slave read data.
- busy  out  1  at least one outstanding transaction or a locked request.

Behaviour:
- Reset (resetn low, asynchronous): FIFO empty, count 0, lock IDLE, RR pointer = D. All outputs 0 after reset.
- Lock FSM states: IDLE, LOCK_I, LOCK_D.
- IDLE arbitration, combinational, same cycle:
  - If count == OUTSTANDING: no grant, s_req = 0.
  - Else if d_req: grant D.
  - Else if i_req: grant I.
- s_* mux:
  - Grant D: s_* = d_*.
  - Grant I: s_wr = 0, s_size = 2, s_wstrb = 0, s_wdata = 0, s_addr = i_addr.
- Grant with s_addr_ok = 0 → next state LOCK_x.
- LOCK_x:
  - Grant stays on x regardless of the other requester's req or priority.
  - s_req = 1; the full check is skipped because the slot was reserved at grant.
  - s_addr_ok = 1 → IDLE.
- Accept (s_req && s_addr_ok):
  - The granted requester's x_addr_ok = 1; the other's is 0.
  - Push {src, discard} into the FIFO; discard = (src == I && cancel).
- Response (s_data_ok):
  - Pop the FIFO head.
  - Assert data_ok of head.src unless head.discard = 1.
  - s_data_ok with an empty FIFO is ignored (no pop, no data_ok).
- Zero-latency response (s_addr_ok and s_data_ok in the same cycle with an empty FIFO) is not supported; the slave guarantees data_ok at least 1 cycle after addr_ok.
- Count: count_next = count + push − pop.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap mod OUTSTANDING.
- Full: an IDLE grant is blocked when count == OUTSTANDING. In that same cycle a pop does not unblock the grant; the grant waits one cycle.
- cancel = 1: sets discard on every valid FIFO entry with src = I.
- Lock and cancel:
  - A LOCK_I in progress is not abandoned; it completes and is pushed with discard = 1.
  - A LOCK_D in progress and D entries are unaffected.
- busy = (count != 0) || (state != IDLE).

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: IDLE arbitration is round-robin. The RR pointer flips to the other requester after each accept; when both request, the pointer holder wins.
- Undefined: fixed data-over-fetch priority; no RR register.

Decomposition:
- Shared package mycpu_arb_pkg:
  - SRC_I = 1'b0, SRC_D = 1'b1.
  - Lock state encoding: IDLE = 2'd0, LOCK_I = 2'd1, LOCK_D = 2'd2.
  - Default OUTSTANDING and CNT_W.
  - Entry layout {discard, src}.
- Sub-module arb_src_fifo (depth OUTSTANDING, 2-bit entries) provides:
  - push/pop.
  - Masked discard-set of all src == I entries.
  - full/empty and count outputs.

Test Plan:
- i_req and d_req together, s_addr_ok = 1 → d_addr_ok = 1, i_addr_ok = 0; next cycle i_addr_ok = 1; data_ok returns D then I in order.
- i_req with s_addr_ok held low 3 cycles while d_req rises at cycle 1 → s_addr stays i_addr through acceptance; D is granted the following cycle.
- Push 2 fetches (OUTSTANDING = 2), no data_ok → s_req = 0 and busy = 1. One s_data_ok → i_data_ok = 1, count = 1; the next grant issues the cycle after.
- 2 fetches outstanding, cancel pulse, then 2 s_data_ok with rdata 0x1111 and 0x2222 → i_data_ok stays 0; a d_req issued after is answered with d_data_ok = 1.
- cancel while LOCK_I and s_addr_ok is asserted in the same cycle → entry pushed discarded; its s_data_ok produces no i_data_ok.
- resetn low mid-transfer with count = 1 → all outputs 0 immediately; after release a stray s_data_ok is ignored; ARB_RR_EN run checks I and D alternate under continuous requests.
